// File: rtl/mem_req_types.sv
// Types and constants for the memory request unit: FSM states, lane-enable patterns, bus widths.
package mem_req_types;

    import rv32i_types::*;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  be_t;
    typedef logic [2:0]  funct3_t;
    typedef logic [1:0]  ls2_t;

    typedef enum logic {
        DIR_READ  = 1'b0,
        DIR_WRITE = 1'b1
    } dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam be_t BE_BYTE = 4'b0001;
    localparam be_t BE_HALF = 4'b0011;
    localparam be_t BE_WORD = 4'b1111;

endpackage

// File: rtl/rv32i_types.sv
// RV32I load/store funct3 encodings shared by the core and its memory-side units.
package rv32i_types;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

endpackage

// File: rtl/mem_be_gen.sv
// Combinational lane-enable and misalignment decode from access width and low address bits.
// Zero latency; no handshake.
module mem_be_gen
    import rv32i_types::*;
    import mem_req_types::*;
(
    input  logic [2:0] i_funct3,
    input  logic [1:0] i_ls2,
    input  logic       i_write,
    output logic [3:0] o_be,
    output logic       o_misaligned
);

    always_comb begin
        o_be         = BE_WORD;
        o_misaligned = 1'b0;
        if (i_write) begin
            case (i_funct3)
                sb: o_be = BE_BYTE << i_ls2;
                sh: begin
                    o_be         = BE_HALF << i_ls2;
                    o_misaligned = (i_ls2 == 2'd3);
                end
                // Unknown store widths behave as full-word stores.
                default: o_misaligned = (i_ls2 != 2'd0);
            endcase
        end else begin
            case (i_funct3)
                lb, lbu: o_misaligned = 1'b0;
                lh, lhu: o_misaligned = (i_ls2 == 2'd3);
                default: o_misaligned = (i_ls2 != 2'd0);
            endcase
        end
    end

endmodule

// File: rtl/mem_req_unit.sv
// Registers one CPU load/store, drives the memory strobe, returns a one-cycle cpu_resp (optional MEM_REQ_TIMEOUT_EN).
// Strobe 1 cycle after request, cpu_resp 1 cycle after mem_resp; CPU holds its level request until cpu_resp.
module mem_req_unit
    import mem_req_types::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [2:0]  cpu_funct3,
    input  logic [31:0] cpu_address,
    input  logic [1:0]  cpu_addr_ls2,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_resp,
    output logic        cpu_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    state_t r_state;
    state_t w_state_next;

    word_t  r_addr;
    word_t  r_wdata;
    word_t  r_rdata;
    be_t    r_be;
    dir_t   r_dir;
    logic   r_err;

    logic   w_req;
    logic   w_conflict;
    logic   w_misaligned;
    logic   w_reject;
    logic   w_expire;
    be_t    w_be;

    assign w_req      = cpu_read | cpu_write;
    assign w_conflict = cpu_read & cpu_write;
    assign w_reject   = w_misaligned | w_conflict;

    mem_be_gen u_be_gen (
        .i_funct3     (cpu_funct3),
        .i_ls2        (cpu_addr_ls2),
        .i_write      (cpu_write),
        .o_be         (w_be),
        .o_misaligned (w_misaligned)
    );

`ifdef MEM_REQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    // Count is zero on the first ISSUE cycle, so expiry fires on the TIMEOUT_CYCLES-th strobe cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_expire = (r_state == ISSUE) && !mem_resp &&
                      (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_expire         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_state_next = w_reject ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (mem_resp || w_expire) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_be    <= '0;
            r_dir   <= DIR_READ;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr  <= cpu_address;
                        r_wdata <= cpu_wdata;
                        r_be    <= w_be;
                        r_dir   <= cpu_write ? DIR_WRITE : DIR_READ;
                        r_err   <= w_reject;
                        if (w_reject) begin
                            r_rdata <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_resp) begin
                        if (r_dir == DIR_READ) begin
                            r_rdata <= mem_rdata;
                        end
                    end else if (w_expire) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes decode straight from the state register so reset removes them without a clock.
    assign mem_read        = (r_state == ISSUE) && (r_dir == DIR_READ);
    assign mem_write       = (r_state == ISSUE) && (r_dir == DIR_WRITE);
    assign mem_address     = r_addr;
    assign mem_wdata       = r_wdata;
    assign mem_byte_enable = r_be;

    assign cpu_resp  = (r_state == DONE);
    assign cpu_err   = (r_state == DONE) && r_err;
    assign cpu_rdata = r_rdata;

endmodule

// File: tb/tb_mem_req_unit.sv
// Directed plus randomized bench for mem_req_unit against a width/alignment reference model.
module tb_mem_req_unit;

`ifdef MEM_REQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    localparam int TO    = 4;
`else
    localparam bit TO_EN = 1'b0;
    localparam int TO    = 255;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [2:0]  cpu_funct3 = 3'd0;
    logic [31:0] cpu_address = 32'd0;
    logic [1:0]  cpu_addr_ls2 = 2'd0;
    logic [31:0] cpu_wdata = 32'd0;
    logic [31:0] cpu_rdata;
    logic        cpu_resp;
    logic        cpu_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_resp = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_req_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_read        (cpu_read),
        .cpu_write       (cpu_write),
        .cpu_funct3      (cpu_funct3),
        .cpu_address     (cpu_address),
        .cpu_addr_ls2    (cpu_addr_ls2),
        .cpu_wdata       (cpu_wdata),
        .cpu_rdata       (cpu_rdata),
        .cpu_resp        (cpu_resp),
        .cpu_err         (cpu_err),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Access size in bytes from the RV32I funct3 meaning; unknown encodings are full words.
    function automatic int model_size(input logic wr, input logic [2:0] f3);
        if (!wr && (f3 == 3'd0 || f3 == 3'd4)) return 1;
        if (!wr && (f3 == 3'd1 || f3 == 3'd5)) return 2;
        if (wr && f3 == 3'd0) return 1;
        if (wr && f3 == 3'd1) return 2;
        return 4;
    endfunction

    function automatic logic model_misaligned(input logic wr, input logic [2:0] f3, input logic [1:0] ls2);
        return (int'(ls2) + model_size(wr, f3)) > 4;
    endfunction

    function automatic logic [3:0] model_be(input logic wr, input logic [2:0] f3, input logic [1:0] ls2);
        int lanes;
        if (!wr) return 4'hF;
        lanes = ((1 << model_size(wr, f3)) - 1) << ls2;
        return lanes[3:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_resp"}, {31'd0, cpu_resp}, 32'd0);
        chk({tag, "_strobe"}, {30'd0, mem_read, mem_write}, 32'd0);
    endtask

    // One complete CPU transaction; resp_at is the strobe cycle (1-based) in which mem_resp is driven.
    task automatic run_req(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [1:0] ls2, input logic [31:0] wd,
                           input int resp_at, input logic [31:0] rdat, input bit scramble);
        logic       exp_err;
        logic       timed;
        logic [3:0] exp_be;
        int         n_strobe;
        exp_err  = (rd && wr) || model_misaligned(wr, f3, ls2);
        exp_be   = model_be(wr, f3, ls2);
        timed    = TO_EN && (resp_at > TO);
        n_strobe = timed ? TO : resp_at;

        cpu_read     = rd;
        cpu_write    = wr;
        cpu_funct3   = f3;
        cpu_address  = addr;
        cpu_addr_ls2 = ls2;
        cpu_wdata    = wd;
        tick();
        if (exp_err) begin
            chk("err_strobe", {30'd0, mem_read, mem_write}, 32'd0);
            chk("err_resp", {31'd0, cpu_resp}, 32'd1);
            chk("err_flag", {31'd0, cpu_err}, 32'd1);
            chk("err_rdata", cpu_rdata, 32'd0);
        end else begin
            for (int c = 1; c <= n_strobe; c++) begin
                chk("strobe", {30'd0, mem_read, mem_write}, {30'd0, rd, wr});
                chk("address", mem_address, addr);
                chk("byte_en", {28'd0, mem_byte_enable}, {28'd0, exp_be});
                if (wr) chk("wdata", mem_wdata, wd);
                chk("early_resp", {31'd0, cpu_resp}, 32'd0);
                if (scramble) begin
                    cpu_address  = $urandom & 32'hFFFF_FFFC;
                    cpu_wdata    = $urandom;
                    cpu_funct3   = 3'($urandom_range(0, 7));
                    cpu_addr_ls2 = 2'($urandom_range(0, 3));
                end
                if (c == resp_at) begin
                    mem_resp  = 1'b1;
                    mem_rdata = rdat;
                end
                tick();
                mem_resp  = 1'b0;
                mem_rdata = $urandom;
            end
            chk("done_strobe", {30'd0, mem_read, mem_write}, 32'd0);
            chk("done_resp", {31'd0, cpu_resp}, 32'd1);
            chk("done_err", {31'd0, cpu_err}, {31'd0, timed});
            if (rd) chk("done_rdata", cpu_rdata, timed ? 32'd0 : rdat);
        end
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        tick();
        chk_idle_outputs("no_reissue");
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_resp", {31'd0, cpu_resp}, 32'd0);
        chk("rst_err", {31'd0, cpu_err}, 32'd0);
        chk("rst_strobe", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_addr", mem_address, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_be", {28'd0, mem_byte_enable}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // mem_resp with nothing in flight must be ignored
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        chk_idle_outputs("stray_resp");

        // Directed: sw, sb, sh, lw, misaligned lw, read/write conflict
        run_req(1'b0, 1'b1, 3'd2, 32'h0000_0100, 2'd0, 32'hDEAD_BEEF, 3, 32'd0, 1'b0);
        run_req(1'b0, 1'b1, 3'd0, 32'h0000_0300, 2'd2, 32'h00AB_0000, 1, 32'd0, 1'b0);
        run_req(1'b0, 1'b1, 3'd1, 32'h0000_0304, 2'd1, 32'h00CD_EF00, 2, 32'd0, 1'b0);
        run_req(1'b1, 1'b0, 3'd2, 32'h0000_0200, 2'd0, 32'd0, 1, 32'h1234_5678, 1'b0);
        run_req(1'b1, 1'b0, 3'd2, 32'h0000_0200, 2'd2, 32'd0, 1, 32'h0, 1'b0);
        run_req(1'b1, 1'b1, 3'd2, 32'h0000_0400, 2'd0, 32'h5555_AAAA, 1, 32'h0, 1'b0);
        run_req(1'b1, 1'b0, 3'd5, 32'h0000_0500, 2'd3, 32'd0, 1, 32'h0, 1'b0);
        run_req(1'b0, 1'b1, 3'd0, 32'h0000_0504, 2'd3, 32'h7700_0000, 1, 32'h0, 1'b0);

        // Reset in the middle of ISSUE
        cpu_read     = 1'b1;
        cpu_funct3   = 3'd2;
        cpu_address  = 32'h0000_0600;
        cpu_addr_ls2 = 2'd0;
        tick();
        chk("pre_rst_read", {31'd0, mem_read}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_read", {31'd0, mem_read}, 32'd0);
        chk("async_rst_addr", mem_address, 32'd0);
        chk("async_rst_be", {28'd0, mem_byte_enable}, 32'd0);
        chk("async_rst_resp", {31'd0, cpu_resp}, 32'd0);
        cpu_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        run_req(1'b1, 1'b0, 3'd2, 32'h0000_0600, 2'd0, 32'd0, 2, 32'hCAFE_F00D, 1'b0);

        // Timeout boundary: response on the last allowed cycle, then none at all
        if (TO_EN) begin
            run_req(1'b1, 1'b0, 3'd2, 32'h0000_0700, 2'd0, 32'd0, TO, 32'h0BAD_CAFE, 1'b0);
            run_req(1'b0, 1'b1, 3'd2, 32'h0000_0704, 2'd0, 32'h1111_2222, 1000, 32'd0, 1'b0);
            run_req(1'b1, 1'b0, 3'd0, 32'h0000_0708, 2'd1, 32'd0, TO + 1, 32'h3333_4444, 1'b0);
        end

        // Randomized traffic, including request churn during ISSUE
        for (int i = 0; i < 120; i++) begin
            int          kind;
            logic        rd;
            logic        wr;
            logic [2:0]  f3;
            logic [1:0]  ls2;
            int          sel;
            kind = $urandom_range(0, 19);
            rd   = (kind < 9) || (kind == 19);
            wr   = (kind >= 9);
            ls2  = 2'($urandom_range(0, 3));
            sel  = $urandom_range(0, 5);
            if (!wr) begin
                case (sel)
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end else if (sel == 5) begin
                f3  = 3'($urandom_range(3, 7));
                ls2 = 2'd0;
            end else begin
                f3 = 3'($urandom_range(0, 2));
            end
            run_req(rd, wr, f3, $urandom & 32'hFFFF_FFFC, ls2, $urandom,
                    $urandom_range(1, 6), $urandom, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
